// File: rtl/urv_dmem_responder_if.sv
//------------------------------------------------------------------------------
// urv_dmem_responder_if : urv_cpu data-port bundle (core = master, memory = slave)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface urv_dmem_responder_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_err_o;

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    input  dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o, dm_err_o
  );

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    output dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o, dm_err_o
  );
endinterface

`default_nettype wire

// File: rtl/urv_dmem_responder.sv
//------------------------------------------------------------------------------
// urv_dmem_responder : byte-enabled data RAM slave with wait states and done pulses
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module urv_dmem_responder #(
  parameter int g_mem_words   = 4096,
  parameter int g_wait_states = 2
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  urv_dmem_responder_if.slave   bus
);

  localparam int         c_aw       = $clog2(g_mem_words);
  localparam bit         c_bypass   = (g_wait_states == 0);
  localparam logic [3:0] c_cnt_init = (g_wait_states > 0) ? 4'(g_wait_states - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [31:0]     r_mem [g_mem_words];

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [c_aw-1:0] r_idx;
  logic [31:0]     r_wdata;
  logic [3:0]      r_sel;
  logic            r_is_load;
  logic            r_oor;
  logic            r_err;

  logic            r_ready;
  logic            r_load_done;
  logic            r_store_done;
  logic            r_err_pulse;
  logic [31:0]     r_data_l;

  logic [c_aw-1:0] w_in_idx;
  logic            w_in_oor;
  logic            w_accept;
  logic            w_fire;
  logic            w_from_in;
  logic [c_aw-1:0] w_f_idx;
  logic [31:0]     w_f_data;
  logic [3:0]      w_f_sel;
  logic            w_f_load;
  logic            w_f_oor;
  logic            w_f_err;
  logic            w_wr_en;
  logic            w_unused;

  assign w_in_idx = bus.dm_addr_i[c_aw+1:2];
  assign w_in_oor = |bus.dm_addr_i[31:c_aw+2];
  assign w_unused = ^bus.dm_addr_i[1:0];

  // r_ready is only ever high in IDLE, so it alone qualifies acceptance
  assign w_accept = r_ready && (bus.dm_load_i || bus.dm_store_i);
  assign w_fire   = ((r_state == S_WAIT) && (r_cnt == 4'd0)) || (w_accept && c_bypass);

  // With no wait states the transaction completes on its accept edge, so use the live request
  assign w_from_in = (r_state == S_IDLE);
  assign w_f_idx   = w_from_in ? w_in_idx                 : r_idx;
  assign w_f_data  = w_from_in ? bus.dm_data_s_i          : r_wdata;
  assign w_f_sel   = w_from_in ? bus.dm_data_select_i     : r_sel;
  assign w_f_load  = w_from_in ? bus.dm_load_i            : r_is_load;
  assign w_f_oor   = w_from_in ? w_in_oor                 : r_oor;
  assign w_f_err   = w_from_in ? (w_in_oor || (bus.dm_load_i && bus.dm_store_i)) : r_err;

  assign w_wr_en = w_fire && !w_f_load && !w_f_oor;

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_f_sel[b]) r_mem[w_f_idx][8*b +: 8] <= w_f_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_idx        <= '0;
      r_wdata      <= 32'd0;
      r_sel        <= 4'd0;
      r_is_load    <= 1'b0;
      r_oor        <= 1'b0;
      r_err        <= 1'b0;
      r_ready      <= 1'b0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_data_l     <= 32'd0;
    end else begin
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_err_pulse  <= 1'b0;

      if (w_fire) begin
        r_load_done  <= w_f_load;
        r_store_done <= !w_f_load;
        r_err_pulse  <= w_f_err;
        if (w_f_load) r_data_l <= w_f_oor ? 32'd0 : r_mem[w_f_idx];
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx     <= w_in_idx;
            r_wdata   <= bus.dm_data_s_i;
            r_sel     <= bus.dm_data_select_i;
            r_is_load <= bus.dm_load_i;
            r_oor     <= w_in_oor;
            r_err     <= w_in_oor || (bus.dm_load_i && bus.dm_store_i);
            r_ready   <= 1'b0;
            if (c_bypass) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_cnt_init;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_DONE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dm_ready_o      = r_ready;
  assign bus.dm_data_l_o     = r_data_l;
  assign bus.dm_load_done_o  = r_load_done;
  assign bus.dm_store_done_o = r_store_done;
  assign bus.dm_err_o        = r_err_pulse;

endmodule

`default_nettype wire
